pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage pipelined processor. Compares register fields from the decode, execute, memory and writeback stages and produces the pipeline-latch write enables, flush/bubble controls and ALU operand bypass selects. It also sequences the multi-cycle multiply/divide unit with a start/ready handshake and a watchdog, freezing the front of the pipeline while that unit is busy.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the forward-select encodings, the mult/div FSM states and the
// zero-register constant, plus a small register-match helper.
package pipe_hazard_ctrl_pkg;

  // Operand bypass select encodings
  localparam logic [1:0] FWD_REG = 2'b00;  // value latched in DX
  localparam logic [1:0] FWD_XM  = 2'b01;  // ALU result sitting in XM
  localparam logic [1:0] FWD_WB  = 2'b10;  // writeback data

  // Architectural register 0 is hardwired to zero and never a real producer
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Mult/div sequencing states
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_t;

  // True when a writing producer with destination dst feeds source src
  function automatic logic reg_hit(input logic [4:0] src,
                                   input logic [4:0] dst,
                                   input logic       we);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Bypass select for one ALU operand: picks XM result, WB data or the latched value.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the select is used.
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] m_rd,
  input  logic       m_we,
  input  logic [4:0] w_rd,
  input  logic       w_we,
  output logic [1:0] sel
);

  // The youngest producer (memory stage) wins over writeback
  always_comb begin
    sel = FWD_REG;
    if (reg_hit(src, m_rd, m_we)) begin
      sel = FWD_XM;
    end else if (reg_hit(src, w_rd, w_we)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: latch enables, flush/bubble, bypass selects, mult/div sequencing.
// Latency: all control outputs combinational; FSM and busy counter update on the falling clock edge.
// Backpressure: freezes PC/FD/DX and bubbles XM while mult/div is busy; load-use stalls PC/FD.
// Option macro PIPE_BYPASS_EN: when undefined, no bypass and any in-flight producer stalls decode.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_uses_rt,
  input  logic [4:0] x_rs,
  input  logic [4:0] x_rt,
  input  logic [4:0] x_rd,
  input  logic       x_we,
  input  logic       x_is_load,
  input  logic       x_is_md,
  input  logic       x_br_taken,
  input  logic [4:0] m_rd,
  input  logic [4:0] w_rd,
  input  logic       m_we,
  input  logic       w_we,
  input  logic       md_ready,
  output logic       pc_we,
  output logic       fd_we,
  output logic       dx_we,
  output logic       fd_flush,
  output logic       dx_flush,
  output logic       xm_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_timeout
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MD_MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_stall;
  logic             load_stall;

  // FSM state and busy counter move with the pipeline latches (falling edge)
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Mult/div sequencing: start pulse, busy stall, ready release and watchdog
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    md_start   = 1'b0;
    md_stall   = 1'b0;
    md_timeout = 1'b0;
    md_busy    = (state == ST_MD_BUSY);
    case (state)
      ST_RUN: begin
        // A taken branch in X means the mult/div is on a dead path; never launch it.
        // Holding reset also keeps the start pulse quiet.
        if (reset && x_is_md && !x_br_taken) begin
          md_start  = 1'b1;
          md_stall  = 1'b1;
          state_nxt = ST_MD_BUSY;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_MD_BUSY: begin
        // Ready wins over the watchdog when both land in the same cycle
        if (md_ready) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LIMIT) begin
          md_timeout = 1'b1;
          state_nxt  = ST_RUN;
          cnt_nxt    = '0;
        end else begin
          md_stall = 1'b1;
          cnt_nxt  = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PIPE_BYPASS_EN
  logic [1:0] sel_a, sel_b;

  hazard_fwd_sel u_fwd_a (
    .src  (x_rs),
    .m_rd (m_rd),
    .m_we (m_we),
    .w_rd (w_rd),
    .w_we (w_we),
    .sel  (sel_a)
  );

  hazard_fwd_sel u_fwd_b (
    .src  (x_rt),
    .m_rd (m_rd),
    .m_we (m_we),
    .w_rd (w_rd),
    .w_we (w_we),
    .sel  (sel_b)
  );

  // Only a load result is too late to bypass into the next instruction
  always_comb begin
    fwd_a      = sel_a;
    fwd_b      = sel_b;
    load_stall = x_is_load &&
                 (reg_hit(d_rs, x_rd, 1'b1) || (d_uses_rt && reg_hit(d_rt, x_rd, 1'b1)));
  end
`else
  // Without bypass the X/M operand sources and WB destination are not needed
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{x_rs, x_rt, w_rd, w_we};

  // No bypass: decode must wait for any producer still in X or M
  always_comb begin
    fwd_a      = FWD_REG;
    fwd_b      = FWD_REG;
    load_stall = (x_is_load &&
                  (reg_hit(d_rs, x_rd, 1'b1) || (d_uses_rt && reg_hit(d_rt, x_rd, 1'b1))))
              || reg_hit(d_rs, x_rd, x_we) || reg_hit(d_rs, m_rd, m_we)
              || (d_uses_rt && (reg_hit(d_rt, x_rd, x_we) || reg_hit(d_rt, m_rd, m_we)));
  end
`endif

  // Latch control with priority flush > mult/div stall > load-use stall
  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    dx_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    xm_bubble = 1'b0;
    if (x_br_taken) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (md_stall) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_we     = 1'b0;
      xm_bubble = 1'b1;
    end else if (load_stall) begin
      // Hold PC and FD, let DX take a nop so the dependent instruction waits one cycle
      pc_we    = 1'b0;
      fd_we    = 1'b0;
      dx_flush = 1'b1;
    end
  end

endmodule
